hdmi_bringup_ctrl: RTL

Sequences HDMI transmitter bring-up and test-pattern mode selection in the 27 MHz control domain. Holds the transmitter and the I2C configurator in reset until the PLL locks, then runs configuration with timeout and bounded retry. Once configured it enables video and advances the pattern mode only at frame boundaries, from a button step pulse or an auto-cycle frame counter. Sits between the PLL, `i2c_config`, the button debouncer, and `mv_pattern`.

---
 rtl/hdmi_ctrl_pkg.sv | 17 +
 rtl/cdc_sync_2ff.sv | 22 ++
 rtl/hdmi_bringup_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hdmi_ctrl_pkg.sv
// Shared types and constants for the HDMI bring-up controller.
package hdmi_ctrl_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        HDMI_RST,
        SETTLE,
        CONFIG,
        RUN,
        FAIL
    } state_t;

    localparam int MODE_W      = 4;
    localparam int STATUS_RUN  = 0;
    localparam int STATUS_FAIL = 1;

endpackage

// File: rtl/cdc_sync_2ff.sv
// Two-flop synchronizer with a selectable asynchronous reset value.
module cdc_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= rst_val;
            q    <= rst_val;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hdmi_bringup_ctrl.sv
// HDMI transmitter bring-up sequencer with retrying configuration and
// frame-aligned test-pattern mode stepping.
module hdmi_bringup_ctrl
    import hdmi_ctrl_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYC    = 270000,
    parameter int unsigned SETTLE_CYC      = 27000,
    parameter int unsigned CFG_TIMEOUT_CYC = 27000000,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned MODE_MAX        = 6,
    parameter int unsigned AUTO_FRAMES     = 120
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              vs,
    input  logic              cfg_done,
    input  logic              cfg_error,
    input  logic              step,
    input  logic              auto_en,
    output logic              cfg_rst,
    output logic              hdmi_nreset,
    output logic              video_en,
    output logic [MODE_W-1:0] mode,
    output logic [1:0]        status,
    output state_t            dbg_state
);

    localparam logic [31:0]       HOLD_LAST    = 32'(RST_HOLD_CYC - 1);
    localparam logic [31:0]       SETTLE_LAST  = 32'(SETTLE_CYC - 1);
    localparam logic [31:0]       TIMEOUT_LAST = 32'(CFG_TIMEOUT_CYC - 1);
    localparam logic [1:0]        RETRY_LIM    = 2'(MAX_RETRY);
    localparam logic [MODE_W-1:0] MODE_LAST    = MODE_W'(MODE_MAX);
    localparam logic [15:0]       AUTO_N       = 16'(AUTO_FRAMES);

    logic        locked_s;
    logic        vs_s;
    logic        vs_d;
    logic        vs_rise;
    state_t      state;
    state_t      state_next;
    logic [31:0] cnt;
    logic [1:0]  retry;
    logic        pending;
    logic [15:0] frame_cnt;
    logic        frame_hit;
    logic        nreset_d;
    logic        cfg_rst_d;
    logic        video_en_d;

    cdc_sync_2ff u_sync_lock (
        .clk     (clk),
        .rst     (rst),
        .rst_val (1'b0),
        .d       (pll_locked),
        .q       (locked_s)
    );

    cdc_sync_2ff u_sync_vs (
        .clk     (clk),
        .rst     (rst),
        .rst_val (1'b0),
        .d       (vs),
        .q       (vs_s)
    );

    assign vs_rise   = vs_s & ~vs_d;
    assign frame_hit = auto_en && ((frame_cnt + 16'd1) >= AUTO_N);
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        if (!locked_s) begin
            state_next = WAIT_LOCK;
        end else begin
            case (state)
                WAIT_LOCK: state_next = HDMI_RST;
                HDMI_RST:  if (cnt == HOLD_LAST) state_next = SETTLE;
                SETTLE:    if (cnt == SETTLE_LAST) state_next = CONFIG;
                // An error wins over a simultaneous done.
                CONFIG: begin
                    if (cfg_error || cnt == TIMEOUT_LAST)
                        state_next = (retry < RETRY_LIM) ? HDMI_RST : FAIL;
                    else if (cfg_done)
                        state_next = RUN;
                end
                RUN:       state_next = RUN;
                FAIL:      state_next = FAIL;
                default:   state_next = WAIT_LOCK;
            endcase
        end
    end

    always_comb begin
        nreset_d   = 1'b1;
        cfg_rst_d  = 1'b1;
        video_en_d = 1'b0;
        case (state_next)
            WAIT_LOCK, HDMI_RST: nreset_d = 1'b0;
            CONFIG:              cfg_rst_d = 1'b0;
            RUN: begin
                cfg_rst_d  = 1'b0;
                video_en_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            retry       <= '0;
            vs_d        <= 1'b0;
            hdmi_nreset <= 1'b0;
            cfg_rst     <= 1'b1;
            video_en    <= 1'b0;
            status      <= '0;
        end else begin
            state       <= state_next;
            vs_d        <= vs_s;
            hdmi_nreset <= nreset_d;
            cfg_rst     <= cfg_rst_d;
            video_en    <= video_en_d;
            status[STATUS_RUN]  <= (state_next == RUN);
            status[STATUS_FAIL] <= (state_next == FAIL);
            if (state_next != state)
                cnt <= '0;
            else if (state inside {HDMI_RST, SETTLE, CONFIG})
                cnt <= cnt + 32'd1;
            if (!locked_s)
                retry <= '0;
            else if (state == CONFIG && state_next == HDMI_RST)
                retry <= retry + 2'd1;
        end
    end

    // A step landing on the applying edge is kept for the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode      <= '0;
            pending   <= 1'b0;
            frame_cnt <= '0;
        end else if (state != RUN || !locked_s) begin
            pending   <= 1'b0;
            frame_cnt <= '0;
        end else if (vs_rise && (pending || frame_hit)) begin
            mode      <= (mode >= MODE_LAST) ? '0 : mode + 1'b1;
            pending   <= step;
            frame_cnt <= '0;
        end else begin
            pending <= pending | step;
            if (!auto_en)
                frame_cnt <= '0;
            else if (vs_rise)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule
